// File: rtl/data_ram_responder_pkg.sv
// Shared definitions for the MEM-stage data-RAM responder: bus widths,
// common constants and the responder FSM state encoding.
package data_ram_responder_pkg;

    localparam int DATA_BUS_W = 32;
    localparam int ADDR_BUS_W = 32;
    localparam int BYTE_W     = 8;
    localparam int LANES      = DATA_BUS_W / BYTE_W;
    localparam int WAIT_CNT_W = 4;

    localparam logic RST_ENABLE   = 1'b0;
    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic WRITE_ENABLE = 1'b1;

    localparam logic [DATA_BUS_W-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        DRR_IDLE = 2'd0,
        DRR_BUSY = 2'd1,
        DRR_DONE = 2'd2
    } drr_state_t;

endpackage

// File: rtl/data_ram_bank.sv
// Word array split into four byte-wide banks. Read is asynchronous on the
// word index; each lane is written on the clock edge when we and its
// byte-select bit are both set. Lane 3 (bits 31:24) is byte offset 0,
// matching the big-endian view of the MEM stage. Contents have no reset.
module data_ram_bank
    import data_ram_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] idx,
    input  logic [LANES-1:0]      sel,
    input  logic [DATA_BUS_W-1:0] wdata,
    input  logic                  we,
    output logic [DATA_BUS_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [BYTE_W-1:0] mem [DEPTH];

        // Per-lane synchronous write gated by that lane's select bit
        always_ff @(posedge clk) begin
            if (we && sel[g]) begin
                mem[idx] <= wdata[g*BYTE_W +: BYTE_W];
            end
        end

        assign rdata[g*BYTE_W +: BYTE_W] = mem[idx];
    end

endmodule

// File: rtl/data_ram_responder.sv
// Memory-side responder for the MEM-stage data-RAM request interface.
// A request seen in IDLE is latched, held for WAIT_CYCLES wait states in
// BUSY (stall_req high), serviced against data_ram_bank, and reported in a
// single DONE cycle before returning to IDLE.
// Optional feature macro: DATA_RAM_ERR_EN -- when defined, accesses whose
// upper address bits are non-zero are flagged on ram_err in DONE, stores are
// dropped and loads return zero; otherwise addresses wrap modulo depth.
module data_ram_responder
    import data_ram_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ram_en,
    input  logic                  ram_write_en,
    input  logic [LANES-1:0]      ram_write_sel,
    input  logic [ADDR_BUS_W-1:0] ram_addr,
    input  logic [DATA_BUS_W-1:0] ram_write_data,
    output logic [DATA_BUS_W-1:0] ram_read_data,
    output logic                  stall_req,
    output logic                  ram_err
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES - 1);

    drr_state_t              state;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic [ADDR_WIDTH-1:0]   idx_lat;
    logic                    we_lat;
    logic [LANES-1:0]        sel_lat;
    logic [DATA_BUS_W-1:0]   wdata_lat;
    logic                    oob_lat;

    logic                    req_oob;
    logic                    err_act;
    logic                    access_now;
    logic                    bank_we;
    logic [DATA_BUS_W-1:0]   bank_rdata;

    // True when any byte-address bit above the word index is set
    function automatic logic addr_out_of_range(input logic [ADDR_BUS_W-1:0] a);
        return (a >> (ADDR_WIDTH + 2)) != '0;
    endfunction

    assign req_oob = addr_out_of_range(ram_addr);

`ifdef DATA_RAM_ERR_EN
    assign err_act = oob_lat;
`else
    // Upper address bits are don't-care here; the flag is kept only so the
    // latch logic is identical in both builds.
    logic unused_oob;
    assign unused_oob = oob_lat;
    assign err_act    = 1'b0;
`endif

    // The access is performed on the last BUSY cycle
    assign access_now = (state == DRR_BUSY) && (wait_cnt == '0);
    assign bank_we    = access_now && (we_lat == WRITE_ENABLE) && !err_act;

    data_ram_bank #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank (
        .clk   (clk),
        .idx   (idx_lat),
        .sel   (sel_lat),
        .wdata (wdata_lat),
        .we    (bank_we),
        .rdata (bank_rdata)
    );

    // Stall follows the request in IDLE, held through BUSY, dropped in DONE and in reset
    always_comb begin
        stall_req = 1'b0;
        if (rst != RST_ENABLE) begin
            case (state)
                DRR_IDLE: stall_req = (ram_en == CHIP_ENABLE);
                DRR_BUSY: stall_req = 1'b1;
                default:  stall_req = 1'b0;
            endcase
        end
    end

    // Responder FSM: request latch, wait-state countdown, registered DONE outputs
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state         <= DRR_IDLE;
            wait_cnt      <= '0;
            idx_lat       <= '0;
            we_lat        <= 1'b0;
            sel_lat       <= '0;
            wdata_lat     <= ZERO_WORD;
            oob_lat       <= 1'b0;
            ram_read_data <= ZERO_WORD;
            ram_err       <= 1'b0;
        end else begin
            case (state)
                DRR_IDLE: begin
                    ram_read_data <= ZERO_WORD;
                    ram_err       <= 1'b0;
                    if (ram_en == CHIP_ENABLE) begin
                        idx_lat   <= ram_addr[ADDR_WIDTH+1:2];
                        we_lat    <= ram_write_en;
                        sel_lat   <= ram_write_sel;
                        wdata_lat <= ram_write_data;
                        oob_lat   <= req_oob;
                        wait_cnt  <= WAIT_LOAD;
                        state     <= DRR_BUSY;
                    end
                end
                DRR_BUSY: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end else begin
                        if ((we_lat != WRITE_ENABLE) && !err_act) begin
                            ram_read_data <= bank_rdata;
                        end else begin
                            ram_read_data <= ZERO_WORD;
                        end
                        ram_err <= err_act;
                        state   <= DRR_DONE;
                    end
                end
                DRR_DONE: begin
                    // The request still on the bus is the one just served
                    ram_read_data <= ZERO_WORD;
                    ram_err       <= 1'b0;
                    state         <= DRR_IDLE;
                end
                default: begin
                    ram_read_data <= ZERO_WORD;
                    ram_err       <= 1'b0;
                    state         <= DRR_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_ram_responder.sv
// Bench for data_ram_responder: a WAIT_CYCLES=1 instance and a WAIT_CYCLES=3
// instance share request buses. Table-driven accesses plus hand sequences
// for reset-mid-access, back-to-back requests and out-of-range addresses.
module tb_data_ram_responder;

`ifdef DATA_RAM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en, use3, we;
    logic [3:0]  sel;
    logic [31:0] addr, wdata;

    logic        en1, en3;
    logic [31:0] rd1, rd3, rd_m;
    logic        st1, st3, st_m;
    logic        er1, er3, er_m;

    int errors = 0;
    int checks = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    assign en1  = en & ~use3;
    assign en3  = en & use3;
    assign rd_m = use3 ? rd3 : rd1;
    assign st_m = use3 ? st3 : st1;
    assign er_m = use3 ? er3 : er1;

    data_ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .ram_en(en1), .ram_write_en(we),
        .ram_write_sel(sel), .ram_addr(addr), .ram_write_data(wdata),
        .ram_read_data(rd1), .stall_req(st1), .ram_err(er1)
    );

    data_ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .ram_en(en3), .ram_write_en(we),
        .ram_write_sel(sel), .ram_addr(addr), .ram_write_data(wdata),
        .ram_read_data(rd3), .stall_req(st3), .ram_err(er3)
    );

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        int          exp_stall;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Call just after a rising edge. Presents one request, follows it to DONE,
    // returns just after the rising edge that ends DONE.
    task automatic run_access(input vec_t v, input bit drop_en);
        int  stall_cnt;
        bit  done;
        logic [31:0] exp;
        en = 1'b1; we = v.we; sel = v.sel; addr = v.addr; wdata = v.wdata;
        sb_q.push_back(v.exp_rd);
        stall_cnt = 0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (st_m === 1'b1) begin
                stall_cnt++;
                chk("stall_rd", rd_m, 32'h0);
                chk("stall_err", {31'h0, er_m}, 32'h0);
            end else begin
                done = 1'b1;
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_empty: got none expected entry");
                end else begin
                    exp = sb_q.pop_front();
                    chk("done_rd", rd_m, exp);
                end
                chk("stall_cycles", stall_cnt, v.exp_stall);
                chk("done_err", {31'h0, er_m}, {31'h0, v.exp_err});
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL timeout: got no DONE expected DONE within 40 cycles");
        end
        if (drop_en) begin
            en = 1'b0;
            @(negedge clk);
            chk("idle_err", {31'h0, er_m}, 32'h0);
            chk("idle_stall", {31'h0, st_m}, 32'h0);
            @(posedge clk); #1;
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [3:0] s, input logic [31:0] a,
                                input logic [31:0] d, input logic [31:0] e, input int st,
                                input logic er);
        vec_t v;
        v.we = w; v.sel = s; v.addr = a; v.wdata = d;
        v.exp_rd = e; v.exp_stall = st; v.exp_err = er;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; en = 1'b0; use3 = 1'b0; we = 1'b0;
        sel = 4'h0; addr = 32'h0; wdata = 32'h0;

        vecs.push_back(mk(1, 4'hF, 32'h10,  32'h11223344, 32'h0,        2, 0));
        vecs.push_back(mk(0, 4'h0, 32'h10,  32'h0,        32'h11223344, 2, 0));
        vecs.push_back(mk(1, 4'h4, 32'h11,  32'hAAAAAAAA, 32'h0,        2, 0));
        vecs.push_back(mk(0, 4'h0, 32'h10,  32'h0,        32'h11AA3344, 2, 0));
        vecs.push_back(mk(1, 4'h0, 32'h10,  32'hFFFFFFFF, 32'h0,        2, 0));
        vecs.push_back(mk(0, 4'h0, 32'h13,  32'h0,        32'h11AA3344, 2, 0));
        vecs.push_back(mk(1, 4'hF, 32'h44,  32'h01020304, 32'h0,        2, 0));
        vecs.push_back(mk(1, 4'h3, 32'h46,  32'h77887788, 32'h0,        2, 0));
        vecs.push_back(mk(0, 4'h0, 32'h44,  32'h0,        32'h01027788, 2, 0));
        vecs.push_back(mk(1, 4'hF, 32'hFFC, 32'hCAFEBABE, 32'h0,        2, 0));
        vecs.push_back(mk(0, 4'h0, 32'hFFC, 32'h0,        32'hCAFEBABE, 2, 0));
        vecs.push_back(mk(1, 4'hF, 32'h20,  32'h0BADF00D, 32'h0,        2, 0));

        // Reset state, including stall gating while a request is present
        repeat (2) @(negedge clk);
        chk("rst_rd1", rd1, 32'h0);
        chk("rst_st1", {31'h0, st1}, 32'h0);
        chk("rst_er1", {31'h0, er1}, 32'h0);
        chk("rst_rd3", rd3, 32'h0);
        en = 1'b1;
        #1;
        chk("rst_stall_gate", {31'h0, st1}, 32'h0);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Table of single accesses on the one-wait-state instance
        for (int i = 0; i < vecs.size(); i++) begin
            run_access(vecs[i], 1'b1);
        end

        // Three wait states: stall cycles 0..3, data in cycle 4
        use3 = 1'b1;
        run_access(mk(1, 4'hF, 32'h8, 32'hA5A55A5A, 32'h0,        4, 0), 1'b1);
        run_access(mk(0, 4'h0, 32'h8, 32'h0,        32'hA5A55A5A, 4, 0), 1'b1);
        use3 = 1'b0;

        // Back-to-back loads with enable held through stall and DONE
        run_access(mk(0, 4'h0, 32'h10, 32'h0, 32'h11AA3344, 2, 0), 1'b0);
        run_access(mk(0, 4'h0, 32'h44, 32'h0, 32'h01027788, 2, 0), 1'b1);

        // Reset while a store sits in BUSY: store abandoned
        en = 1'b1; we = 1'b1; sel = 4'hF; addr = 32'h20; wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("rstmid_cycle0_stall", {31'h0, st1}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rstmid_stall", {31'h0, st1}, 32'h0);
        chk("rstmid_rd", rd1, 32'h0);
        @(negedge clk);
        chk("rstmid_stall_held", {31'h0, st1}, 32'h0);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        run_access(mk(0, 4'h0, 32'h20, 32'h0, 32'h0BADF00D, 2, 0), 1'b1);

        // Out-of-range address: flagged and dropped, or wrapped onto word 0
        run_access(mk(1, 4'hF, 32'h0,    32'h12345678, 32'h0, 2, 0), 1'b1);
        run_access(mk(1, 4'hF, 32'h1000, 32'h99999999, 32'h0, 2, ERR_EN), 1'b1);
        run_access(mk(0, 4'h0, 32'h0,    32'h0,
                      ERR_EN ? 32'h12345678 : 32'h99999999, 2, 0), 1'b1);
        run_access(mk(0, 4'h0, 32'h1000, 32'h0,
                      ERR_EN ? 32'h0 : 32'h99999999, 2, ERR_EN), 1'b1);

        chk("sb_drained", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
